// File: rtl/debug_cmd_pkg.sv
// Shared constants, state type and status-word layout for the debug UART
// command-frame parser.
package debug_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] OP_PING  = 8'h50;  // 'P'
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_CR  = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        ARG0,
        ARG1,
        TERM,
        EXEC,
        DRAIN
    } parser_state_t;

    localparam int SW_FRAME_LSB = 24;
    localparam int SW_ERR_LSB   = 16;
    localparam int SW_OP_LSB    = 8;
    localparam int SW_ADDR_LSB  = 0;

    function automatic logic [31:0] pack_status(input logic [7:0] frames,
                                                input logic [7:0] errs,
                                                input logic [7:0] op,
                                                input logic [7:0] addr);
        logic [31:0] w;
        w = '0;
        w[SW_FRAME_LSB +: 8] = frames;
        w[SW_ERR_LSB   +: 8] = errs;
        w[SW_OP_LSB    +: 8] = op;
        w[SW_ADDR_LSB  +: 8] = addr;
        return w;
    endfunction

endpackage

// File: rtl/debug_cmd_parser_if.sv
// Byte-stream input and decoded strobe/status outputs of the debug command
// parser; slave is the parser side, master the byte source / consumer side.
interface debug_cmd_parser_if;

    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_strobe;
    logic [7:0]  rd_addr;
    logic        ping_pulse;
    logic        err_pulse;
    logic        busy;
    logic [31:0] status_word;

    modport master (
        output cmd_byte, cmd_valid,
        input  wr_strobe, wr_addr, wr_data, rd_strobe, rd_addr,
        input  ping_pulse, err_pulse, busy, status_word
    );

    modport slave (
        input  cmd_byte, cmd_valid,
        output wr_strobe, wr_addr, wr_data, rd_strobe, rd_addr,
        output ping_pulse, err_pulse, busy, status_word
    );

endinterface

// File: rtl/debug_cmd_parser.sv
// Decodes opcode/argument/LF frames from the debug UART into one-cycle write,
// read and ping strobes, with an inter-byte timeout and a packed status word.
module debug_cmd_parser
    import debug_cmd_pkg::*;
#(
    parameter logic [27:0] TIMEOUT_TICKS = 28'd22000000
) (
    input  logic              clk_in,
    input  logic              reset,
    debug_cmd_parser_if.slave bus
);

    parser_state_t state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [27:0] tmo_q, tmo_d;
    logic        err_d, exec_d;

    logic        err_q, wr_strobe_q, rd_strobe_q, ping_q;
    logic [7:0]  wr_addr_q, wr_data_q, rd_addr_q;
    logic [7:0]  frame_cnt_q, err_cnt_q, last_op_q, last_addr_q;

    logic [7:0]  rx_byte;
    logic        rx_valid;

    assign rx_byte  = bus.cmd_byte;
    assign rx_valid = bus.cmd_valid;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tmo_d    = '0;
        err_d    = 1'b0;
        exec_d   = 1'b0;

        unique case (state_q)
            // EXEC lasts one cycle and accepts a new opcode exactly like IDLE
            IDLE, EXEC: begin
                state_d = IDLE;
                if (rx_valid && rx_byte != CHAR_LF && rx_byte != CHAR_CR) begin
                    opcode_d = rx_byte;
                    if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                        state_d = ARG0;
                    end else if (rx_byte == OP_PING) begin
                        state_d = TERM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            ARG0: begin
                if (rx_valid) begin
                    addr_d  = rx_byte;
                    state_d = (opcode_q == OP_WRITE) ? ARG1 : TERM;
                end
            end
            ARG1: begin
                if (rx_valid) begin
                    data_d  = rx_byte;
                    state_d = TERM;
                end
            end
            TERM: begin
                if (rx_valid) begin
                    if (rx_byte == CHAR_LF) begin
                        exec_d  = 1'b1;
                        state_d = EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rx_valid && rx_byte == CHAR_LF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An arriving byte always beats the timeout and leaves the counter cleared
        if (!rx_valid && state_q != IDLE && state_q != EXEC) begin
            if (tmo_q == TIMEOUT_TICKS - 28'd1) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + 28'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            ping_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            last_op_q   <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            wr_strobe_q <= exec_d && (opcode_q == OP_WRITE);
            rd_strobe_q <= exec_d && (opcode_q == OP_READ);
            ping_q      <= exec_d && (opcode_q == OP_PING);
            if (exec_d && opcode_q == OP_WRITE) begin
                wr_addr_q <= addr_q;
                wr_data_q <= data_q;
            end
            if (exec_d && opcode_q == OP_READ) begin
                rd_addr_q <= addr_q;
            end
            // Status fields trail the strobe/error pulse by one cycle
            if (state_q == EXEC) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                last_op_q   <= opcode_q;
                last_addr_q <= (opcode_q == OP_PING) ? 8'd0 : addr_q;
            end
            if (err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.wr_strobe   = wr_strobe_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_strobe   = rd_strobe_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.ping_pulse  = ping_q;
    assign bus.err_pulse   = err_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.status_word = pack_status(frame_cnt_q, err_cnt_q, last_op_q, last_addr_q);

endmodule

// File: doc/debug_cmd_parser.md
# debug_cmd_parser

Frame parser for the debug UART receive path. Consumes the byte stream from the debug `uart_rx` (`debug_command` / `debug_command_pulse`) and decodes fixed-format ASCII-opcode frames into one-cycle register write, register read and ping strobes. Exports a packed status word sized to drive the periodic debug transmitter's `data_in` at `DATA_WIDTH = 32`, so frame and error counts appear on the TX link.

## Interface
- `TIMEOUT_TICKS`, 28'd22000000: idle-gap limit between bytes of one frame, in `clk_in` cycles (about 1 s at 22 MHz).
- `clk_in` input 1: sole clock.
- `reset` input 1: synchronous, active-low reset (asserted when 0, sampled on `posedge clk_in`).
- `cmd_byte` input 8: received byte; valid only when `cmd_valid` is 1.
- `cmd_valid` input 1: one-cycle pulse per received byte.
- `wr_strobe` output 1: one-cycle register-write pulse.
- `wr_addr` output 8: write address; held until the next write.
- `wr_data` output 8: write data; held until the next write.
- `rd_strobe` output 1: one-cycle register-read pulse.
- `rd_addr` output 8: read address; held until the next read.
- `ping_pulse` output 1: one-cycle pulse on a valid ping frame.
- `err_pulse` output 1: one-cycle pulse on any framing error or timeout.
- `busy` output 1: 1 whenever state ≠ IDLE.
- `status_word` output 32: {`frame_count`[7:0], `err_count`[7:0], `last_opcode`[7:0], `last_addr`[7:0]}.

## Operation
- Frame = opcode byte, 0–2 argument bytes, terminator 0x0A.
  - 'W' (0x57): addr, data.
  - 'R' (0x52): addr.
  - 'P' (0x50): no arguments.
- States: IDLE, ARG0, ARG1, TERM, EXEC, DRAIN.
- IDLE:
  - 0x0A and 0x0D are ignored.
  - 'W' or 'R' → ARG0.
  - 'P' → TERM.
  - Any other byte → `err_pulse`, then DRAIN.
  - The opcode is latched internally on every accepted byte except ignored ones.
- ARG0: latch the address. 'W' → ARG1; 'R' → TERM.
- ARG1: latch the data → TERM.
- TERM:
  - 0x0A → EXEC.
  - Any other byte → `err_pulse`, then DRAIN. No strobe is issued.
- EXEC (exactly one cycle):
  - Issue `wr_strobe`, `rd_strobe` or `ping_pulse`, according to the opcode.
  - Update `wr_addr`/`wr_data` or `rd_addr`.
  - Update `last_opcode` and `last_addr` (`last_addr` = 0 for 'P').
  - Increment `frame_count`, which wraps 0xFF → 0x00.
  - Return to IDLE.
  - A `cmd_valid` arriving in the EXEC cycle is processed exactly as IDLE would process it.
- DRAIN: discard bytes until 0x0A, then return to IDLE. The 0x0A does not produce a second error.
- Timeout:
  - A counter clears on every accepted byte and increments every cycle while state ∉ {IDLE, EXEC}.
  - When it reaches `TIMEOUT_TICKS-1`: `err_pulse`, return to IDLE, clear the counter.
  - Timeout applies in DRAIN too.
  - If the timeout and `cmd_valid` coincide, the byte wins and the counter clears.
- `err_count` increments on each `err_pulse` and saturates at 0xFF.
- Arguments may take any value, including 0x0A; ARG states never treat 0x0A as a terminator.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - All outputs 0, state IDLE, counters 0, latched opcode/addr/data 0.
  - Mid-frame reset discards the partial frame with no pulse.
- Byte accepted on the edge where `cmd_valid` = 1. State updates on that edge.
- Strobe latency: the terminator is accepted on edge N; EXEC occupies cycle N→N+1 and the strobe is high during it.
- `wr_addr`/`wr_data`/`rd_addr` become valid in the same cycle the strobe rises.
- `err_pulse` is registered: high in the cycle after the offending byte's edge, or after the timeout edge.
- `status_word` updates in the cycle after EXEC or after an error.
- No backpressure. Upstream bytes are at least 10 × `UART_TICKS_PER_BIT` apart.

## Structure
- `debug_cmd_pkg`:
  - opcode constants (`OP_WRITE`, `OP_READ`, `OP_PING`, `CHAR_LF`, `CHAR_CR`);
  - state enum `parser_state_t`;
  - `status_word` field offsets.
- No sub-module. The timeout counter and FSM live in one always block on `clk_in`.
- Instantiated beside the debugger: fed from its `debug_command`/`debug_command_pulse`; `status_word` drives its `data_in`.

## Test plan
- Bytes 'W',0x12,0x34,0x0A → single `wr_strobe`, `wr_addr` = 0x12, `wr_data` = 0x34, `frame_count` = 1, `err_count` = 0.
- 'R',0x0A,0x0A → `rd_strobe`, `rd_addr` = 0x0A (argument 0x0A is not a terminator); `status_word` = 0x0100520A.
- 'X',0x41,0x0A then 'P',0x0A → one `err_pulse`; then `ping_pulse`; `err_count` = 1, `frame_count` = 1.
- 'W',0x01 then silence for `TIMEOUT_TICKS` cycles → `err_pulse` at the exact cycle, `busy` falls, no `wr_strobe`; a following 'P',0x0A succeeds.
- 'W',0x05,0x06,0x0B → `err_pulse`, DRAIN; 0x0A → IDLE with no second error; no `wr_strobe`.
- `reset` = 0 asserted after 'W',0x01 → all outputs 0; subsequent 0x02,0x0A → error path (0x02 is an unknown opcode), no write.
